axi_decoder_cfg_sequencer: RTL and testbench
============================================

Name: axi_decoder_cfg_sequencer

Overview:
- AXI4-Lite master that loads the 3L-NPC decoder's S00_AXI register file from a parallel configuration word on a single start pulse.
- Sequences one write per register, optionally reads each back and compares, then reports done/error.
- Sits between a local controller (or PS GPIO) and the decoder's slave port, so the decoder is configured atomically without software AXI traffic.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, byte-address width of the master port.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- NUM_REGS, 4, number of consecutive 32-bit registers to program (1..16, addresses within the address space).
- BASE_ADDR, 0, byte address of register 0; register k is at BASE_ADDR + 4*k.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; ignored while busy=1
- cfg_data  in  NUM_REGS*32  register k at bits [32k+31:32k]; sampled on the accepted start cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of sequence
- err  out  1  sticky error flag for the last sequence; cleared on the next accepted start
- err_idx  out  4  index of the first failing register; valid when err=1
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32; M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WVALID  out  1; M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH; M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1; M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All VALID/READY outputs, busy, done and err are 0; err_idx=0; FSM goes to IDLE; the index counter is 0.
  - Reset mid-transaction abandons the sequence with no done pulse.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, FIN.
- IDLE:
  - On start: capture cfg_data into the shadow register, set idx=0, clear err, go to WR_ADDR_DATA.
  - Start is never queued.
- WR_ADDR_DATA:
  - AWVALID and WVALID assert together on entry.
  - Each drops independently on its own VALID&READY handshake.
  - Advance when both handshakes are complete, in either order or the same cycle.
  - VALID never drops before its handshake; AWADDR/WDATA are stable while VALID is high.
- WR_RESP:
  - BREADY=1; on BVALID, BRESP!=2'b00 sets err, sets err_idx=idx and goes to FIN.
  - Otherwise, if idx==NUM_REGS-1 go to the read phase with idx=0; else idx+1 and back to WR_ADDR_DATA.
- RD_ADDR: ARVALID=1 with ARADDR=BASE_ADDR+4*idx until ARREADY.
- RD_DATA:
  - RREADY=1; on RVALID, RRESP!=OKAY or RDATA!=shadow[idx] records the error and goes to FIN.
  - Else advance idx, or go to FIN after the last register.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, return to IDLE.
- Latency with zero-wait slave: 2 cycles per write, 2 cycles per read, plus 1 cycle for FIN.
- Address arithmetic is modulo 2^C_M_AXI_ADDR_WIDTH; the idx counter width is clog2(NUM_REGS)+1 to avoid wrap at NUM_REGS=16.
- Only one outstanding transaction at any time.

Optional Feature:
- Macro: AXI_DECODER_CFG_READBACK_EN.
- Defined: read/compare phase as above.
- Undefined: after the last write response the FSM goes directly to FIN. RD states and the compare logic are absent; ARVALID and RREADY are tied 0. err reflects only BRESP.

Decomposition:
- Package axi_decoder_cfg_pkg holds:
  - the state enum;
  - AXI_RESP_OKAY / SLVERR / DECERR constants;
  - AWPROT/WSTRB defaults.
- One sub-module is natural: axi_lite_wr_channel. It owns the independent AW/W valid-drop logic and exposes req/ack to the FSM.

Test Plan:
- cfg_data={32'h4,32'h3,32'h2,32'h1}, zero-wait slave -> writes to 0x0,0x4,0x8,0xC with data 1..4; readbacks match; done pulse; err=0; busy high for 17 cycles.
- AWREADY delayed 3 cycles with WREADY immediate, then the reverse -> each VALID holds until its own handshake; one write per register; data correct.
- Slave returns BRESP=2'b10 on register 2 -> err=1, err_idx=2, no further AW issued, done pulse.
- Slave corrupts RDATA for register 3 (returns 32'hDEAD) -> err=1, err_idx=3, done.
- start pulsed while busy, and ARESETN dropped during WR_RESP -> second start ignored. Reset forces all VALIDs/busy to 0 asynchronously with no done. A new start after reset runs a clean sequence.
- Macro undefined -> no ARVALID ever; done after the 4th BRESP; busy high for 9 cycles.

Source files
------------

// File: rtl/axi_decoder_cfg_sequencer_pkg.sv
`default_nettype none
// ==== axi_decoder_cfg_pkg : shared states and AXI constants for the decoder cfg sequencer ====
// Rev 1.0
package axi_decoder_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WR_RESP      = 3'd2;
  localparam logic [2:0] ST_RD_ADDR      = 3'd3;
  localparam logic [2:0] ST_RD_DATA      = 3'd4;
  localparam logic [2:0] ST_FIN          = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
  localparam logic [3:0] AXI_WSTRB_DEFAULT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/axi_decoder_cfg_sequencer_axi_lite_wr_channel.sv
`default_nettype none
// ==== axi_lite_wr_channel : issues one AW/W pair per req; each VALID retires on its own handshake ====
// Rev 1.0
module axi_lite_wr_channel #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ack,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready
);

  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;

  assign awvalid = req & ~aw_done;
  assign wvalid  = req & ~w_done;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  // Handshakes may land in either order or together; ack the cycle the second one completes.
  assign ack = req & (aw_done | aw_hs) & (w_done | w_hs);

  assign awaddr = addr;
  assign wdata  = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (ack) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_decoder_cfg_sequencer.sv
`default_nettype none
// ==== axi_decoder_cfg_sequencer : AXI4-Lite master loading NUM_REGS decoder registers on start ====
// Rev 1.0 -- read/compare phase enabled by AXI_DECODER_CFG_READBACK_EN
module axi_decoder_cfg_sequencer
  import axi_decoder_cfg_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4,
  parameter int BASE_ADDR          = 0
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          start,
  input  logic [NUM_REGS*32-1:0]        cfg_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [3:0]                    err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  // One extra bit so the counter never wraps even at NUM_REGS=16.
  localparam int IDX_W = $clog2(NUM_REGS) + 1;

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [NUM_REGS*32-1:0]          shadow;
  logic [31:0]                     cur_word;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   cur_addr;
  logic                            last;
  logic                            wr_ack;

  assign last     = (idx == IDX_W'(NUM_REGS - 1));
  assign cur_addr = C_M_AXI_ADDR_WIDTH'(BASE_ADDR) + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});

  always_comb begin
    cur_word = 32'h0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == IDX_W'(k)) cur_word = shadow[k*32 +: 32];
    end
  end

  axi_lite_wr_channel #(
    .ADDR_WIDTH (C_M_AXI_ADDR_WIDTH),
    .DATA_WIDTH (C_M_AXI_DATA_WIDTH)
  ) u_wr_channel (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .req     (state == ST_WR_ADDR_DATA),
    .addr    (cur_addr),
    .data    (cur_word),
    .ack     (wr_ack),
    .awaddr  (M_AXI_AWADDR),
    .awvalid (M_AXI_AWVALID),
    .awready (M_AXI_AWREADY),
    .wdata   (M_AXI_WDATA),
    .wvalid  (M_AXI_WVALID),
    .wready  (M_AXI_WREADY)
  );

  assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
  assign M_AXI_ARPROT = AXI_PROT_DEFAULT;
  assign M_AXI_WSTRB  = AXI_WSTRB_DEFAULT;
  assign M_AXI_ARADDR = cur_addr;
  assign M_AXI_BREADY = (state == ST_WR_RESP);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_FIN);

`ifdef AXI_DECODER_CFG_READBACK_EN
  assign M_AXI_ARVALID = (state == ST_RD_ADDR);
  assign M_AXI_RREADY  = (state == ST_RD_DATA);
`else
  logic unused_rd_channel;
  assign M_AXI_ARVALID     = 1'b0;
  assign M_AXI_RREADY      = 1'b0;
  assign unused_rd_channel = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= ST_IDLE;
      idx     <= '0;
      shadow  <= '0;
      err     <= 1'b0;
      err_idx <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shadow  <= cfg_data;
            idx     <= '0;
            err     <= 1'b0;
            err_idx <= 4'd0;
            state   <= ST_WR_ADDR_DATA;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (wr_ack) state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != AXI_RESP_OKAY) begin
              err     <= 1'b1;
              err_idx <= 4'(idx);
              state   <= ST_FIN;
            end else if (last) begin
              idx   <= '0;
`ifdef AXI_DECODER_CFG_READBACK_EN
              state <= ST_RD_ADDR;
`else
              state <= ST_FIN;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_WR_ADDR_DATA;
            end
          end
        end
`ifdef AXI_DECODER_CFG_READBACK_EN
        ST_RD_ADDR: begin
          if (M_AXI_ARREADY) state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (M_AXI_RVALID) begin
            if ((M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RDATA != cur_word)) begin
              err     <= 1'b1;
              err_idx <= 4'(idx);
              state   <= ST_FIN;
            end else if (last) begin
              state <= ST_FIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD_ADDR;
            end
          end
        end
`endif
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_decoder_cfg_sequencer.sv
`default_nettype none
// tb_axi_decoder_cfg_sequencer : randomized AXI4-Lite slave with a transaction-level model of the sequencer.
module tb_axi_decoder_cfg_sequencer;

  localparam int AW   = 4;
  localparam int NR   = 4;
  localparam int BASE = 0;
`ifdef AXI_DECODER_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [NR*32-1:0] cfg_data = '0;
  logic             busy, done, err;
  logic [3:0]       err_idx;
  logic [AW-1:0]    awaddr, araddr;
  logic [2:0]       awprot, arprot;
  logic             awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]       bresp = 2'b00, rresp = 2'b00;
  logic [31:0]      rdata = 32'h0;

  axi_decoder_cfg_sequencer #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (32),
    .NUM_REGS           (NR),
    .BASE_ADDR          (BASE)
  ) u_dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .start         (start),
    .cfg_data      (cfg_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_idx       (err_idx),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs, set by the stimulus.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int fail_b = -1, corrupt_r = -1;
  int b_base = 0, r_base = 0;

  // Transaction logs, owned by the posedge monitor.
  logic [AW-1:0] aw_log[$];
  logic [31:0]   w_log[$];
  logic [AW-1:0] ar_log[$];
  int b_cnt = 0, r_cnt = 0;
  int busy_cyc = 0, done_total = 0, arvalid_cyc = 0, rready_cyc = 0, prot_err = 0;
  logic aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
  logic [AW-1:0] aw_hold = '0, ar_hold = '0;
  logic [31:0]   w_hold = '0;

  always @(posedge clk) begin
    if (busy)    busy_cyc++;
    if (done)    done_total++;
    if (arvalid) arvalid_cyc++;
    if (rready)  rready_cyc++;
    if (!rst_n) begin
      aw_log.delete(); w_log.delete(); ar_log.delete();
      b_cnt = 0; r_cnt = 0;
      aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
    end else begin
      if (aw_stall && (!awvalid || awaddr != aw_hold)) prot_err++;
      if (w_stall  && (!wvalid  || wdata  != w_hold))  prot_err++;
      if (ar_stall && (!arvalid || araddr != ar_hold)) prot_err++;
      if (awvalid && aw_log.size() != b_cnt) prot_err++;
      if (wvalid  && w_log.size()  != b_cnt) prot_err++;
      if (arvalid && (ar_log.size() != r_cnt || aw_log.size() != b_cnt)) prot_err++;
      aw_stall = awvalid && !awready; aw_hold = awaddr;
      w_stall  = wvalid  && !wready;  w_hold  = wdata;
      ar_stall = arvalid && !arready; ar_hold = araddr;
      if (awvalid && awready) aw_log.push_back(awaddr);
      if (wvalid && wready)   w_log.push_back(wdata);
      if (bvalid && bready)   b_cnt++;
      if (arvalid && arready) ar_log.push_back(araddr);
      if (rvalid && rready)   r_cnt++;
    end
  end

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    logic [31:0] d;
    d = 32'h0;
    for (int i = 0; i < aw_log.size() && i < w_log.size(); i++)
      if (aw_log[i] == a) d = w_log[i];
    return d;
  endfunction

  // Slave driver: responds on the falling edge from what the DUT shows in the current cycle.
  int aw_seen = 0, w_seen = 0, ar_seen = 0, b_wait = 0, r_wait = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (awvalid) begin awready = (aw_seen >= aw_dly); aw_seen++; end
      else begin awready = 1'b0; aw_seen = 0; end
      if (wvalid) begin wready = (w_seen >= w_dly); w_seen++; end
      else begin wready = 1'b0; w_seen = 0; end
      if (arvalid) begin arready = (ar_seen >= ar_dly); ar_seen++; end
      else begin arready = 1'b0; ar_seen = 0; end
      if (((aw_log.size() < w_log.size()) ? aw_log.size() : w_log.size()) > b_cnt) begin
        bvalid = (b_wait >= b_dly);
        bresp  = ((b_cnt - b_base) == fail_b) ? 2'b10 : 2'b00;
        b_wait++;
      end else begin
        bvalid = 1'b0; bresp = 2'b00; b_wait = 0;
      end
      if (ar_log.size() > r_cnt) begin
        rvalid = (r_wait >= r_dly);
        rresp  = 2'b00;
        rdata  = ((r_cnt - r_base) == corrupt_r) ? 32'hDEAD : mem_rd(ar_log[r_cnt]);
        r_wait++;
      end else begin
        rvalid = 1'b0; r_wait = 0;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, err, err_idx, awvalid, wvalid, bready, arvalid, rready}, '0);
    rst_n = 1'b1;
  endtask

  task automatic run_seq(input logic [NR*32-1:0] cfg, input int awd, input int wd, input int bd,
                         input int ard, input int rd, input int fb, input int cr, input bit dbl_start);
    int exp_w, exp_r, exp_lat, exp_eidx;
    bit exp_err, seen;
    int aw0, w0, ar0, busy0, done0, arv0, rr0, pe0;
    logic [AW-1:0] ea;
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    fail_b = fb; corrupt_r = cr;
    if (fb >= 0) begin
      exp_w = fb + 1; exp_r = 0; exp_err = 1'b1; exp_eidx = fb;
    end else begin
      exp_w = NR;
      exp_r = RB ? ((cr >= 0) ? cr + 1 : NR) : 0;
      exp_err = RB && (cr >= 0);
      exp_eidx = exp_err ? cr : 0;
    end
    exp_lat = exp_w * (((awd > wd) ? awd : wd) + bd + 2) + exp_r * (ard + rd + 2) + 1;

    @(negedge clk);
    aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size();
    b_base = b_cnt; r_base = r_cnt;
    busy0 = busy_cyc; done0 = done_total; arv0 = arvalid_cyc; rr0 = rready_cyc; pe0 = prot_err;
    start = 1'b1;
    cfg_data = cfg;
    @(negedge clk);
    start = 1'b0;
    cfg_data = ~cfg;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin seen = 1'b1; break; end
      start = dbl_start && (c == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("err", err, exp_err);
    if (exp_err) check("err_idx", err_idx, exp_eidx);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_single_cycle", done, 0);
    check("err_sticky", err, exp_err);
    check("done_count", done_total - done0, 1);
    check("busy_cycles", busy_cyc - busy0, exp_lat);
    check("aw_count", aw_log.size() - aw0, exp_w);
    check("w_count", w_log.size() - w0, exp_w);
    check("ar_count", ar_log.size() - ar0, exp_r);
    check("arvalid_cycles", arvalid_cyc - arv0, exp_r * (ard + 1));
    check("rready_cycles", rready_cyc - rr0, exp_r * (rd + 1));
    check("protocol", prot_err - pe0, 0);
    for (int k = 0; k < exp_w && (aw0 + k) < aw_log.size() && (w0 + k) < w_log.size(); k++) begin
      ea = AW'(BASE + 4 * k);
      check("wr_addr", aw_log[aw0 + k], ea);
      check("wr_data", w_log[w0 + k], cfg[32*k +: 32]);
    end
    for (int k = 0; k < exp_r && (ar0 + k) < ar_log.size(); k++) begin
      ea = AW'(BASE + 4 * k);
      check("rd_addr", ar_log[ar0 + k], ea);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NR*32-1:0] rcfg;
    int d0;
    bit ok;

    do_reset;
    check("const_prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});

    run_seq({32'h4, 32'h3, 32'h2, 32'h1}, 0, 0, 0, 0, 0, -1, -1, 1'b0);
    run_seq({32'hA0A0_0004, 32'hB0B0_0003, 32'hC0C0_0002, 32'hD0D0_0001}, 3, 0, 0, 0, 0, -1, -1, 1'b0);
    run_seq({32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888}, 0, 3, 0, 0, 0, -1, -1, 1'b0);
    run_seq({32'h4, 32'h3, 32'h2, 32'h1}, 0, 0, 0, 0, 0, 2, -1, 1'b0);
    run_seq({32'h4, 32'h3, 32'h2, 32'h1}, 0, 0, 0, 0, 0, -1, 3, 1'b0);
    run_seq({32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004}, 1, 2, 1, 1, 1, -1, -1, 1'b1);

    // Asynchronous reset while waiting on the second write response.
    aw_dly = 0; w_dly = 0; b_dly = 2; fail_b = -1; corrupt_r = -1;
    @(negedge clk);
    b_base = b_cnt;
    d0 = done_total;
    start = 1'b1;
    cfg_data = {32'h0BAD_0004, 32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001};
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bready && (b_cnt - b_base) == 1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("reached_wr_resp", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, awvalid, wvalid, bready, arvalid, rready}, '0);
    repeat (3) @(negedge clk);
    check("no_done_on_reset", done_total - d0, 0);
    check("reset_err", {err, err_idx}, '0);
    rst_n = 1'b1;
    run_seq({32'h0000_0040, 32'h0000_0030, 32'h0000_0020, 32'h0000_0010}, 0, 0, 0, 0, 0, -1, -1, 1'b0);

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < NR; k++) rcfg[32*k +: 32] = $urandom;
      run_seq(rcfg, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NR - 1)) : -1,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NR - 1)) : -1,
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
